// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, loader states and loader error codes.
// Imported by the program loader and the control decoder.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_ST   = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1101;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } ld_state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/byte_packer.sv
// Shifts stream bytes MSB-first into an instruction word.
// word is the completed word while word_ready is high.
module byte_packer #(
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [7:0]         din,
  output logic [INSTR_W-1:0] word,
  output logic               word_ready
);

  localparam int NB = INSTR_W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [IW-1:0] idx;

  assign word_ready = en && (idx == IW'(NB - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= word_ready ? '0 : idx + IW'(1);
    end
  end

  if (NB > 1) begin : g_sr
    logic [INSTR_W-9:0] sr;

    assign word = {sr, din};

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        sr <= '0;
      end else if (en) begin
        sr <= word[INSTR_W-9:0];
      end
    end
  end else begin : g_one
    assign word = din;
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames count, words and checksum into
// instruction memory while holding the CPU in reset.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 256,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic [1:0]         err,
  output logic               illegal_op,
  output logic [AW-1:0]      illegal_addr
);

  ld_state_t state, state_n;

  logic [15:0]        cnt, cnt_n;
  logic [7:0]         sum, sum_n;
  logic [AW-1:0]      wa, wa_n;
  logic [AW-1:0]      addr_n, ila_n;
  logic [INSTR_W-1:0] wdata_n;
  logic               we_n, hold_n, done_n, ill_n, rdy_n;
  logic [1:0]         err_n;
  logic               acc, arm;
  logic [INSTR_W-1:0] word;
  logic               word_ready;

  assign acc = in_valid && in_ready;

  byte_packer #(.INSTR_W(INSTR_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (arm),
    .en         (acc && (state == S_DATA)),
    .din        (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sum_n   = sum;
    wa_n    = wa;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    hold_n  = cpu_hold;
    done_n  = done;
    err_n   = err;
    ill_n   = illegal_op;
    ila_n   = illegal_addr;
    arm     = 1'b0;
    if (acc) sum_n = sum + in_data;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: arm = start;
      S_CNT_HI: begin
        if (acc) begin
          cnt_n   = {in_data, 8'h00};
          state_n = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (acc) begin
          cnt_n = {cnt[15:8], in_data};
          if (32'(cnt_n) > 32'(DEPTH)) begin
            state_n = S_ERR;
            err_n   = ERR_LEN;
          end else if (cnt_n == 16'd0) begin
            state_n = S_CSUM;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_ready) begin
          we_n    = 1'b1;
          addr_n  = wa;
          wdata_n = word;
          // only the first offending word is recorded
          if (word[INSTR_W-1 -: 4] >= OP_ILLEGAL_MIN && !illegal_op) begin
            ill_n = 1'b1;
            ila_n = wa;
          end
          wa_n = wa + AW'(1);
          if (17'(wa) + 17'd1 == 17'(cnt)) state_n = S_CSUM;
        end
      end
      S_CSUM: begin
        if (acc) begin
          if (sum_n == 8'h00) begin
            state_n = S_DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = S_ERR;
            err_n   = ERR_CSUM;
          end
        end
      end
      default: ;
    endcase
    if (arm) begin
      state_n = S_CNT_HI;
      sum_n   = 8'h00;
      wa_n    = '0;
      done_n  = 1'b0;
      err_n   = ERR_NONE;
      ill_n   = 1'b0;
      ila_n   = '0;
      hold_n  = 1'b1;
    end
    rdy_n = (state_n == S_CNT_HI) || (state_n == S_CNT_LO) ||
            (state_n == S_DATA) || (state_n == S_CSUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sum          <= '0;
      wa           <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= ERR_NONE;
      illegal_op   <= 1'b0;
      illegal_addr <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sum          <= sum_n;
      wa           <= wa_n;
      in_ready     <= rdy_n;
      mem_we       <= we_n;
      mem_addr     <= addr_n;
      mem_wdata    <= wdata_n;
      cpu_hold     <= hold_n;
      done         <= done_n;
      err          <= err_n;
      illegal_op   <= ill_n;
      illegal_addr <= ila_n;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued as bytes
// are driven, popped when mem_we is seen.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic [1:0]  err;
  logic        illegal_op;
  logic [7:0]  illegal_addr;

  int checks = 0;
  int failures = 0;
  int nwrites = 0;

  logic [39:0] sbq[$];
  logic [31:0] fw[$];
  logic        exp_ill;
  logic [7:0]  exp_ila;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .illegal_op   (illegal_op),
    .illegal_addr (illegal_addr)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      logic [39:0] e;
      nwrites++;
      if (sbq.size() == 0) begin
        check("unexpected_we", {56'd0, mem_addr}, 64'hffff);
      end else begin
        e = sbq.pop_front();
        check("we_addr", {56'd0, mem_addr}, {56'd0, e[39:32]});
        check("we_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_ill = 1'b0;
    exp_ila = 8'd0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] cadj);
    logic [7:0] s;
    logic [7:0] b;
    logic [31:0] w;
    s = 8'h00;
    b = n[15:8];
    s += b;
    send_byte(b);
    b = n[7:0];
    s += b;
    send_byte(b);
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      for (int j = 0; j < 4; j++) begin
        b = w[31 - 8*j -: 8];
        s += b;
        if (j == 3) begin
          sbq.push_back({8'(i), w});
          if (w[31:28] >= 4'hE && !exp_ill) begin
            exp_ill = 1'b1;
            exp_ila = 8'(i);
          end
        end
        send_byte(b);
      end
    end
    send_byte(8'h00 - s + cadj);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, {63'd0, in_ready}, 0);
    check({tag, "_we"}, {63'd0, mem_we}, 0);
    check({tag, "_addr"}, {56'd0, mem_addr}, 0);
    check({tag, "_wdata"}, {32'd0, mem_wdata}, 0);
    check({tag, "_hold"}, {63'd0, cpu_hold}, 0);
    check({tag, "_done"}, {63'd0, done}, 0);
    check({tag, "_err"}, {62'd0, err}, 0);
    check({tag, "_ill"}, {63'd0, illegal_op}, 0);
    check({tag, "_ila"}, {56'd0, illegal_addr}, 0);
  endtask

  task automatic check_end(input string tag, input logic d,
                           input logic [1:0] e, input logic h);
    @(negedge clk);
    check({tag, "_done"}, {63'd0, done}, {63'd0, d});
    check({tag, "_err"}, {62'd0, err}, {62'd0, e});
    check({tag, "_hold"}, {63'd0, cpu_hold}, {63'd0, h});
    check({tag, "_ill"}, {63'd0, illegal_op}, {63'd0, exp_ill});
    check({tag, "_ila"}, {56'd0, illegal_addr}, {56'd0, exp_ila});
    check({tag, "_sb_empty"}, sbq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    exp_ill = 1'b0;
    exp_ila = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // good two-word frame
    do_start();
    check("armed_hold", {63'd0, cpu_hold}, 1);
    check("armed_ready", {63'd0, in_ready}, 1);
    fw = '{32'h1123_4567, 32'h9000_0004};
    send_frame(2, 8'h00);
    check_end("good", 1'b1, 2'b00, 1'b0);

    // bad checksum: writes still happen
    do_start();
    send_frame(2, 8'h01);
    check_end("badsum", 1'b0, 2'b10, 1'b1);

    // oversize count
    do_start();
    w0 = nwrites;
    send_byte(8'h01);
    send_byte(8'h01);
    check_end("len", 1'b0, 2'b01, 1'b1);
    check("len_ready", {63'd0, in_ready}, 0);
    check("len_nowrite", nwrites, w0);

    // illegal opcode in the middle word
    do_start();
    fw = '{32'h1000_0001, 32'hE000_0000, 32'h2000_0002};
    send_frame(3, 8'h00);
    check_end("illop", 1'b1, 2'b00, 1'b0);

    // empty program
    do_start();
    w0 = nwrites;
    send_frame(0, 8'h00);
    check_end("empty", 1'b1, 2'b00, 1'b0);
    check("empty_nowrite", nwrites, w0);

    // reset after five data bytes
    do_start();
    sbq.push_back({8'd0, 32'h1123_4567});
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h23);
    send_byte(8'h45);
    send_byte(8'h67);
    send_byte(8'h90);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    w0 = nwrites;
    check_idle("midrst");
    repeat (5) @(negedge clk);
    check("midrst_nowrite", nwrites, w0);
    check("midrst_sb", sbq.size(), 0);
    do_start();
    fw = '{32'h1123_4567, 32'h9000_0004};
    send_frame(2, 8'h00);
    check_end("reload", 1'b1, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Writes programs into the instruction memory that the control decoder's fetch path reads from. It accepts a byte stream over a valid/ready handshake, typically fed by the UART receiver. It assembles the bytes into instruction words, writes them to consecutive instruction-memory addresses, and checks every opcode field against the 4-bit ISA. While it loads, it holds the CPU in reset, and it verifies a trailing checksum before releasing the CPU.

## Interface
- `INSTR_W`, default 32: instruction width in bits, a multiple of 8; the opcode is `word[INSTR_W-1 -: 4]`.
- `DEPTH`, default 256: instruction-memory depth in words.
- `AW`, default $clog2(DEPTH): address width.
- `clk  in  1`: the single clock; every register updates on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle pulse that arms a load.
- `in_valid  in  1`: stream byte is valid.
- `in_data  in  8`: stream byte.
- `in_ready  out  1`: loader accepts a byte; transfer happens when `in_valid & in_ready`.
- `mem_we  out  1`: instruction-memory write strobe.
- `mem_addr  out  AW`: write address.
- `mem_wdata  out  INSTR_W`: write data.
- `cpu_hold  out  1`: holds the CPU in reset while loading.
- `done  out  1`: load completed without error; level output.
- `err  out  2`: 00 none, 01 length, 10 checksum.
- `illegal_op  out  1`: sticky flag; at least one written word had opcode 1110 or 1111.
- `illegal_addr  out  AW`: address of the first illegal-opcode word.

## Operation
- Frame layout, all bytes MSB-first:
  - count hi, count lo (N = number of words);
  - N×(INSTR_W/8) data bytes;
  - one checksum byte.
- Checksum rule: the 8-bit sum of every frame byte, including the count and checksum bytes, must equal 0x00.
- States: IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
- IDLE → CNT_HI on `start`. Entering CNT_HI:
  - clears the sum, address, byte index, `done`, `err`, `illegal_op` and `illegal_addr`;
  - sets `cpu_hold` = 1.
- CNT_HI → CNT_LO on a byte.
- CNT_LO, on a byte:
  - N > DEPTH → ERR with `err` = 01;
  - N = 0 → CSUM;
  - otherwise → DATA.
- DATA: each byte shifts into the word register. When the last byte of a word is accepted:
  - a write issues;
  - if the opcode is 1110 or 1111 and `illegal_op` is 0, set `illegal_op` and capture the address;
  - the address increments;
  - after word N → CSUM.
- CSUM, on a byte:
  - running sum + byte = 0 → DONE, `done` = 1, `cpu_hold` = 0;
  - otherwise → ERR, `err` = 10.
- ERR keeps `cpu_hold` = 1 and stays until `start` or `rst`.
- `start` in DONE or ERR restarts the load (→ CNT_HI with the clears above).
- `start` in CNT_HI, CNT_LO, DATA or CSUM is ignored.
- An illegal opcode is reported only; the word is still written and the load continues.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0;
  - `cpu_hold` 0, `done` 0, `err` 00, `illegal_op` 0, `illegal_addr` 0.
- Reset mid-load aborts immediately: no further writes, and all outputs return to their reset values on the next edge.
- `in_ready` is a registered function of state: 1 in CNT_HI, CNT_LO, DATA and CSUM; 0 otherwise. The loader never back-pressures inside a frame.
- `mem_we` is a one-cycle registered pulse in the cycle after the last byte of a word is accepted.
  - `mem_addr` and `mem_wdata` are valid in that same cycle and hold until the next write.
- `done`, `err` and `cpu_hold` change in the cycle after the deciding byte is accepted.
- The address never wraps: the N ≤ DEPTH check guarantees the final address is ≤ DEPTH-1.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (the 4-bit values 0000–1101 plus `OP_ILLEGAL_MIN` = 4'b1110);
  - the loader state enum;
  - the `err` codes.
- The control decoder imports the same opcode constants from `cpu_pkg`.
- One sub-module, `byte_packer`: shifts bytes into an INSTR_W word and asserts `word_ready` on the final byte. Everything else lives in the top-level FSM.

## Test plan
- Frame: N = 2, INSTR_W = 32, words 0x1123_4567 and 0x9000_0004, correct checksum → two `mem_we` pulses at addresses 0 and 1 with those words; then `done` = 1, `cpu_hold` = 0, `illegal_op` = 0.
- Same frame with the checksum byte off by 1 → both writes occur, then `err` = 10, `done` = 0, `cpu_hold` stays 1.
- N = 257 with DEPTH = 256 → ERR with `err` = 01 after count lo; no `mem_we`; `in_ready` = 0.
- N = 3 with a second word of 0xE000_0000 → all 3 words written, `illegal_op` = 1, `illegal_addr` = 1, `done` = 1.
- N = 0 followed by checksum 0x00 → no writes, `done` = 1.
- `rst` pulse after 5 data bytes → no further `mem_we`, outputs at reset values; a following `start` plus a good frame loads correctly from address 0.
